// File: rtl/ipd_pkg.sv
// Shared constants, FSM state encoding and duty saturation for the I-PD sample sequencer.
//   DATA_W : width of setpoint / measurement / IPD result (two's complement)
//   PWM_W  : width of the unsigned PWM duty word
package ipd_pkg;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned PWM_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_ACQ       = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_WAIT_RES  = 3'd4,
    ST_UPDATE    = 3'd5
  } state_e;

  // Clamp a signed IPD result into the unsigned duty range [0, 2^PWM_W-1].
  function automatic logic [PWM_W-1:0] sat_duty(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] lim;
    lim = {{(DATA_W-PWM_W){1'b0}}, {PWM_W{1'b1}}};
    if (x[DATA_W-1]) begin
      return '0;
    end else if (x > lim) begin
      return '1;
    end else begin
      return x[PWM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period down-counter: produces a one-cycle tick every SAMPLE_DIV enabled cycles.
//   clock, reset : system clock, async active-low reset
//   load_i       : reload counter with SAMPLE_DIV-1 (has priority over en_i)
//   en_i         : count down while high; wraps to SAMPLE_DIV-1 after 0
//   tick_c       : combinational, high while enabled and the counter is 0
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, wrap at zero, or decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = en_i && (cnt_q == '0);

endmodule

// File: rtl/ipd_sample_sequencer.sv
// Runs one I-PD control iteration per sample period: trigger the ADC, latch the
// measurement and setpoint, pulse the IPD, wait for its result, saturate to PWM duty.
//   clock, reset            : system clock, async active-low reset
//   run, clear_flags        : loop enable (level), sticky-flag clear (pulse)
//   referencia_in           : host setpoint
//   adc_start/adc_done/adc_data : ADC handshake and measured position
//   referencia, y_k         : held operands to the IPD datapath
//   ipd_enable, ipd_reset   : IPD compute and clear strobes
//   salida_IPD              : IPD result
//   duty, duty_valid        : saturated PWM duty and its update strobe
//   busy, overrun, adc_timeout : status
module ipd_sample_sequencer
  import ipd_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 50000,
  parameter int unsigned ADC_TIMEOUT = 1024,
  parameter int unsigned IPD_LAT     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              clear_flags,
  input  logic [DATA_W-1:0] referencia_in,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] referencia,
  output logic [DATA_W-1:0] y_k,
  output logic              ipd_enable,
  output logic              ipd_reset,
  input  logic [DATA_W-1:0] salida_IPD,
  output logic [PWM_W-1:0]  duty,
  output logic              duty_valid,
  output logic              busy,
  output logic              overrun,
  output logic              adc_timeout
);

  localparam int unsigned TO_W  = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam int unsigned LAT_W = $clog2(IPD_LAT + 1);

  state_e            state_q, state_d;
  logic              run_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] ref_q, ref_d;
  logic [DATA_W-1:0] yk_q, yk_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic              adc_start_q, adc_start_d;
  logic              ipd_enable_q, ipd_enable_d;
  logic              ipd_reset_q, ipd_reset_d;
  logic              duty_valid_q, duty_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic tick_load;
  logic tick_en;
  logic tick;

  // Counter only runs while the loop is armed; IDLE freezes it until the next run rise.
  assign tick_en = run && (state_q != ST_IDLE);

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .load_i (tick_load),
    .en_i   (tick_en),
    .tick_c (tick)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    ref_d        = ref_q;
    yk_d         = yk_q;
    duty_d       = duty_q;
    adc_start_d  = 1'b0;
    ipd_enable_d = 1'b0;
    ipd_reset_d  = 1'b0;
    duty_valid_d = 1'b0;
    overrun_d    = overrun_q & ~clear_flags;
    timeout_d    = timeout_q & ~clear_flags;
    tick_load    = 1'b0;

    if ((state_q != ST_IDLE) && !run) begin
      // Loop stopped: force a safe zero duty and announce it.
      state_d      = ST_IDLE;
      duty_d       = '0;
      duty_valid_d = 1'b1;
    end else begin
      // A tick outside WAIT_TICK is dropped; the running iteration carries on.
      if (tick && (state_q != ST_WAIT_TICK)) begin
        overrun_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (run && !run_q) begin
            ipd_reset_d = 1'b1;
            tick_load   = 1'b1;
            state_d     = ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (tick) begin
            adc_start_d = 1'b1;
            to_cnt_d    = '0;
            state_d     = ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (adc_done) begin
            yk_d         = adc_data;
            ref_d        = referencia_in;
            ipd_enable_d = 1'b1;
            state_d      = ST_COMPUTE;
          end else if (to_cnt_q == TO_W'(ADC_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_WAIT_TICK;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_COMPUTE: begin
          lat_cnt_d = LAT_W'(IPD_LAT);
          state_d   = ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          // Last wait cycle: salida_IPD is valid at this edge.
          if (lat_cnt_q == LAT_W'(1)) begin
            duty_d       = sat_duty(salida_IPD);
            duty_valid_d = 1'b1;
            state_d      = ST_UPDATE;
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
          end
        end
        ST_UPDATE: begin
          state_d = ST_WAIT_TICK;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_ACQ) || (state_d == ST_COMPUTE) ||
             (state_d == ST_WAIT_RES) || (state_d == ST_UPDATE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      to_cnt_q     <= '0;
      lat_cnt_q    <= '0;
      ref_q        <= '0;
      yk_q         <= '0;
      duty_q       <= '0;
      adc_start_q  <= 1'b0;
      ipd_enable_q <= 1'b0;
      ipd_reset_q  <= 1'b0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run;
      to_cnt_q     <= to_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      ref_q        <= ref_d;
      yk_q         <= yk_d;
      duty_q       <= duty_d;
      adc_start_q  <= adc_start_d;
      ipd_enable_q <= ipd_enable_d;
      ipd_reset_q  <= ipd_reset_d;
      duty_valid_q <= duty_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign referencia  = ref_q;
  assign y_k         = yk_q;
  assign ipd_enable  = ipd_enable_q;
  assign ipd_reset   = ipd_reset_q;
  assign duty        = duty_q;
  assign duty_valid  = duty_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign adc_timeout = timeout_q;

endmodule

// File: tb/tb_ipd_sample_sequencer.sv
// Directed bench for ipd_sample_sequencer with SAMPLE_DIV=16, ADC_TIMEOUT=1024, IPD_LAT=2.
module tb_ipd_sample_sequencer;
  import ipd_pkg::*;

  logic              clock;
  logic              reset;
  logic              run;
  logic              clear_flags;
  logic [DATA_W-1:0] referencia_in;
  logic              adc_start;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] referencia;
  logic [DATA_W-1:0] y_k;
  logic              ipd_enable;
  logic              ipd_reset;
  logic [DATA_W-1:0] salida_IPD;
  logic [PWM_W-1:0]  duty;
  logic              duty_valid;
  logic              busy;
  logic              overrun;
  logic              adc_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen_st, seen_en, seen_dv;

  ipd_sample_sequencer #(
    .SAMPLE_DIV  (16),
    .ADC_TIMEOUT (1024),
    .IPD_LAT     (2)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .clear_flags   (clear_flags),
    .referencia_in (referencia_in),
    .adc_start     (adc_start),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .referencia    (referencia),
    .y_k           (y_k),
    .ipd_enable    (ipd_enable),
    .ipd_reset     (ipd_reset),
    .salida_IPD    (salida_IPD),
    .duty          (duty),
    .duty_valid    (duty_valid),
    .busy          (busy),
    .overrun       (overrun),
    .adc_timeout   (adc_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step negedges until the selected output is 1; n = cycles waited, -1 if the budget ran out.
  task automatic wait_for(input int sel, input int max, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < max) begin
      @(negedge clock);
      n++;
      seen_st |= adc_start;
      seen_en |= ipd_enable;
      seen_dv |= duty_valid;
      case (sel)
        0:       hit = adc_start;
        1:       hit = duty_valid;
        2:       hit = adc_timeout;
        default: hit = 1'b0;
      endcase
    end
    if (!hit) n = -1;
  endtask

  // Drive adc_done at the current negedge and follow the iteration to its duty update.
  task automatic complete_iter(input logic [DATA_W-1:0] y, input logic [DATA_W-1:0] r,
                               input logic [DATA_W-1:0] s, input logic [PWM_W-1:0] d);
    int n;
    adc_done      = 1'b1;
    adc_data      = y;
    referencia_in = r;
    @(negedge clock);
    adc_done   = 1'b0;
    adc_data   = '0;
    salida_IPD = s;
    check_eq("y_k_latch", y_k, y);
    check_eq("ref_latch", referencia, r);
    check_eq("ipd_enable", ipd_enable, 1);
    wait_for(1, 10, n);
    check_eq("done_to_valid", n, 3);
    check_eq("duty", duty, d);
    check_eq("busy_update", busy, 1);
  endtask

  logic [DATA_W-1:0] v_y [8];
  logic [DATA_W-1:0] v_r [8];
  logic [DATA_W-1:0] v_s [8];
  logic [PWM_W-1:0]  v_d [8];

  initial begin
    int n;
    v_y[0] = 19'd100;    v_r[0] = 19'd100;    v_s[0] = 19'd1234;    v_d[0] = 12'd1234;
    v_y[1] = 19'h7FFFD;  v_r[1] = 19'd250;    v_s[1] = 19'h7FFFB;   v_d[1] = 12'd0;
    v_y[2] = 19'd77;     v_r[2] = 19'h7FFFF;  v_s[2] = 19'd5000;    v_d[2] = 12'd4095;
    v_y[3] = 19'd4000;   v_r[3] = 19'd4001;   v_s[3] = 19'd4095;    v_d[3] = 12'd4095;
    v_y[4] = 19'd1;      v_r[4] = 19'd2;      v_s[4] = 19'd4096;    v_d[4] = 12'd4095;
    v_y[5] = 19'd0;      v_r[5] = 19'd5;      v_s[5] = 19'h40000;   v_d[5] = 12'd0;
    v_y[6] = 19'd9;      v_r[6] = 19'd9;      v_s[6] = 19'h3FFFF;   v_d[6] = 12'd4095;
    v_y[7] = 19'd3;      v_r[7] = 19'd4;      v_s[7] = 19'd1;       v_d[7] = 12'd1;

    reset = 1'b0; run = 1'b0; clear_flags = 1'b0; referencia_in = '0;
    adc_done = 1'b0; adc_data = '0; salida_IPD = '0;
    seen_st = 1'b0; seen_en = 1'b0; seen_dv = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_duty", duty, 0);
    check_eq("rst_y_k", y_k, 0);
    check_eq("rst_ref", referencia, 0);
    check_eq("rst_adc_start", adc_start, 0);
    check_eq("rst_ipd_enable", ipd_enable, 0);
    check_eq("rst_ipd_reset", ipd_reset, 0);
    check_eq("rst_duty_valid", duty_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_timeout", adc_timeout, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Run rise: ipd_reset next cycle, first adc_start 16 cycles after the rise.
    run = 1'b1;
    @(negedge clock);
    check_eq("ipd_reset_rise", ipd_reset, 1);
    check_eq("busy_wait_tick", busy, 0);
    wait_for(0, 40, n);
    check_eq("first_tick", n, 16);
    check_eq("ipd_reset_pulse", ipd_reset, 0);
    check_eq("busy_acq", busy, 1);

    // Nominal iterations with saturation corner values.
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clock);
      complete_iter(v_y[i], v_r[i], v_s[i], v_d[i]);
      wait_for(0, 40, n);
      check_eq("sample_period", n, 9);
    end
    check_eq("no_overrun", overrun, 0);
    check_eq("no_timeout", adc_timeout, 0);

    // ADC never answers.
    seen_en = 1'b0; seen_dv = 1'b0;
    wait_for(2, 1100, n);
    check_eq("timeout_cycles", n, 1024);
    check_eq("timeout_no_enable", seen_en, 0);
    check_eq("timeout_no_valid", seen_dv, 0);
    check_eq("timeout_duty_hold", duty, 1);
    check_eq("timeout_overrun", overrun, 1);
    check_eq("timeout_not_busy", busy, 0);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    check_eq("clear_overrun", overrun, 0);
    check_eq("clear_timeout", adc_timeout, 0);
    wait_for(0, 40, n);
    check_eq("restart_tick", n, 15);
    repeat (3) @(negedge clock);
    complete_iter(19'd50, 19'd60, 19'd42, 12'd42);
    wait_for(0, 40, n);
    check_eq("restart_period", n, 9);

    // Late ADC answer; clear_flags coincides with the dropped tick.
    repeat (14) @(negedge clock);
    check_eq("pre_overrun", overrun, 0);
    @(negedge clock);
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    check_eq("overrun_set_wins", overrun, 1);
    check_eq("overrun_no_timeout", adc_timeout, 0);
    repeat (4) @(negedge clock);
    complete_iter(19'd200, 19'd201, 19'd777, 12'd777);
    wait_for(0, 40, n);
    check_eq("tick_dropped", n, 8);

    // Run dropped during WAIT_RES.
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    check_eq("overrun_cleared", overrun, 0);
    repeat (2) @(negedge clock);
    adc_done = 1'b1; adc_data = 19'd555; referencia_in = 19'd556; salida_IPD = 19'd900;
    @(negedge clock);
    adc_done = 1'b0;
    check_eq("drop_ipd_enable", ipd_enable, 1);
    @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    check_eq("drop_duty", duty, 0);
    check_eq("drop_duty_valid", duty_valid, 1);
    check_eq("drop_busy", busy, 0);
    check_eq("drop_y_k_hold", y_k, 19'd555);
    check_eq("drop_ref_hold", referencia, 19'd556);
    @(negedge clock);
    check_eq("drop_valid_pulse", duty_valid, 0);
    adc_done = 1'b1; adc_data = 19'd999; referencia_in = 19'd998;
    @(negedge clock);
    adc_done = 1'b0;
    seen_st = 1'b0; seen_en = 1'b0; seen_dv = 1'b0;
    wait_for(3, 20, n);
    check_eq("idle_no_start", seen_st, 0);
    check_eq("idle_no_enable", seen_en, 0);
    check_eq("idle_no_valid", seen_dv, 0);
    check_eq("idle_y_k_ignored", y_k, 19'd555);
    check_eq("idle_duty", duty, 0);

    // Re-arm, one iteration, then async reset in the middle of ACQ.
    run = 1'b1;
    @(negedge clock);
    check_eq("rearm_ipd_reset", ipd_reset, 1);
    wait_for(0, 40, n);
    check_eq("rearm_first_tick", n, 16);
    repeat (3) @(negedge clock);
    complete_iter(19'd11, 19'd12, 19'd321, 12'd321);
    wait_for(0, 40, n);
    check_eq("rearm_period", n, 9);
    check_eq("pre_rst_start", adc_start, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_adc_start", adc_start, 0);
    check_eq("arst_duty", duty, 0);
    check_eq("arst_y_k", y_k, 0);
    check_eq("arst_ref", referencia, 0);
    check_eq("arst_busy", busy, 0);
    run = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("post_rst_valid", duty_valid, 0);
    check_eq("post_rst_ipd_reset", ipd_reset, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
